// File: rtl/rx_serial_8n1_pkg.sv
// Shared definitions for the 8N1 serial receiver: frame width, default bit period, state codes.
// The state encoding doubles as the debug display code.
package rx_serial_8n1_pkg;

  localparam int N_BITS           = 8;
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [2:0] {
    inicial        = 3'd0,
    confirma_start = 3'd1,
    recebe_dados   = 3'd2,
    verifica_stop  = 3'd3,
    final_ok       = 3'd4,
    erro           = 3'd5,
    espera_idle    = 3'd6
  } estado_t;

  function automatic logic [3:0] codigo_estado(input estado_t e);
    if (e <= espera_idle) return {1'b0, e};
    return 4'hF;
  endfunction

endpackage

// File: rtl/rx_serial_8n1_if.sv
// Receiver-side bundle: serial line in, received byte plus status strobes out.
// No backpressure; the consumer samples dado on fim_recepcao.
interface rx_serial_8n1_if;
  import rx_serial_8n1_pkg::*;

  logic              RX;
  logic              fim_recepcao;
  logic [N_BITS-1:0] dado;
  logic              erro_stop;
  logic              ocupado;
  logic [3:0]        db_estado;

  modport master (input RX, output fim_recepcao, dado, erro_stop, ocupado, db_estado);
  modport slave  (output RX, input fim_recepcao, dado, erro_stop, ocupado, db_estado);

endinterface

// File: rtl/rx_serial_8n1_cnt.sv
// Modulo-M tick counter: zera clears (priority), conta advances and wraps at M-1.
// fim flags the terminal count, meio flags the half-period count; no backpressure.
module contador_m #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim,
  output logic meio
);

  logic [N-1:0] q;

  always_ff @(posedge clock) begin
    if (!reset || zera) q <= '0;
    else if (conta)     q <= fim ? '0 : q + 1'b1;
  end

  assign fim  = (q == N'(M - 1));
  assign meio = (q == N'(M / 2 - 1));

endmodule

// File: rtl/rx_serial_8n1_uc.sv
// Control unit of the 8N1 receiver: frames start/data/stop and raises registered result strobes.
// Strobes last exactly one cycle; no backpressure is accepted.
module rx_serial_8n1_uc
  import rx_serial_8n1_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_s,
  input  logic       fim_bit,
  input  logic       meio_bit,
  input  logic       ultimo_bit,
  output logic       zera_cnt,
  output logic       desloca,
  output logic       zera_idx,
  output logic       carrega,
  output logic       fim_recepcao,
  output logic       erro_stop,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  estado_t estado;
  logic    conta;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado       <= inicial;
      fim_recepcao <= 1'b0;
      erro_stop    <= 1'b0;
    end else begin
      fim_recepcao <= 1'b0;
      erro_stop    <= 1'b0;
      case (estado)
        inicial:        if (!rx_s) estado <= confirma_start;
        confirma_start: if (meio_bit) estado <= rx_s ? inicial : recebe_dados;
        recebe_dados:   if (fim_bit && ultimo_bit) estado <= verifica_stop;
        verifica_stop:
          if (fim_bit) begin
            if (rx_s) begin
              estado       <= final_ok;
              fim_recepcao <= 1'b1;
            end else begin
              estado    <= erro;
              erro_stop <= 1'b1;
            end
          end
        final_ok:       estado <= inicial;
        erro:           estado <= espera_idle;
        espera_idle:    if (rx_s) estado <= inicial;
        default:        estado <= inicial;
      endcase
    end
  end

  // The half-bit confirm window ends with a counter clear so data bits start on a fresh period.
  assign conta     = (estado == confirma_start) || (estado == recebe_dados) ||
                     (estado == verifica_stop);
  assign zera_cnt  = !conta || ((estado == confirma_start) && meio_bit);
  assign desloca   = (estado == recebe_dados) && fim_bit;
  assign zera_idx  = (estado == confirma_start);
  assign carrega   = (estado == verifica_stop) && fim_bit && rx_s;
  assign ocupado   = (estado == recebe_dados) || (estado == verifica_stop) ||
                     (estado == final_ok);
  assign db_estado = codigo_estado(estado);

endmodule

// File: rtl/rx_serial_8n1.sv
// UART 8N1 receiver: 2-FF synchronizer, mid-bit sampling, framing-error detection.
// Byte valid 1 cycle after the stop-bit sample; no backpressure, dado held until next byte.
module rx_serial_8n1
  import rx_serial_8n1_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int W_CNT        = 9
) (
  input logic             clock,
  input logic             reset,
  rx_serial_8n1_if.master bus
);

  logic              rx_ff1;
  logic              rx_s;
  logic [N_BITS-1:0] shift_reg;
  logic [2:0]        idx;
  logic              fim_bit;
  logic              meio_bit;
  logic              zera_cnt;
  logic              desloca;
  logic              zera_idx;
  logic              carrega;

  contador_m #(.M(CLKS_PER_BIT), .N(W_CNT)) u_cnt (
    .clock (clock),
    .reset (reset),
    .zera  (zera_cnt),
    .conta (1'b1),
    .fim   (fim_bit),
    .meio  (meio_bit)
  );

  rx_serial_8n1_uc u_uc (
    .clock        (clock),
    .reset        (reset),
    .rx_s         (rx_s),
    .fim_bit      (fim_bit),
    .meio_bit     (meio_bit),
    .ultimo_bit   (idx == 3'd7),
    .zera_cnt     (zera_cnt),
    .desloca      (desloca),
    .zera_idx     (zera_idx),
    .carrega      (carrega),
    .fim_recepcao (bus.fim_recepcao),
    .erro_stop    (bus.erro_stop),
    .ocupado      (bus.ocupado),
    .db_estado    (bus.db_estado)
  );

  // Line is LSB first, so each sample enters at the MSB and walks down.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_ff1    <= 1'b1;
      rx_s      <= 1'b1;
      shift_reg <= '0;
      idx       <= '0;
      bus.dado  <= '0;
    end else begin
      rx_ff1 <= bus.RX;
      rx_s   <= rx_ff1;
      if (zera_idx)                    idx <= '0;
      else if (desloca && idx != 3'd7) idx <= idx + 1'b1;
      if (desloca) shift_reg <= {rx_s, shift_reg[N_BITS-1:1]};
      if (carrega) bus.dado  <= shift_reg;
    end
  end

endmodule

// File: tb/tb_rx_serial_8n1.sv
// Directed plus randomized frames against a frame-level timing/data model of the receiver.
module tb_rx_serial_8n1;

  localparam int C   = 8;
  localparam int H   = C / 2;
  // RX edge -> two sync stages -> FSM sees it one edge later, then half bit + 9 bit periods.
  localparam int LAT = 3 + H + 9 * C;

  logic clock = 1'b0;
  logic reset;

  rx_serial_8n1_if bus();

  rx_serial_8n1 #(.CLKS_PER_BIT(C), .W_CNT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned cyc     = 0;
  int unsigned total   = 0;
  int unsigned bad     = 0;
  int unsigned both_hi = 0;

  int unsigned fim_t[$];
  int unsigned err_t[$];
  int unsigned exp_fim_t[$];
  int unsigned exp_err_t[$];
  logic [7:0]  fim_d[$];
  logic [7:0]  exp_fim_d[$];
  logic [7:0]  last_good;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.fim_recepcao === 1'b1) begin
      fim_t.push_back(cyc);
      fim_d.push_back(bus.dado);
    end
    if (bus.erro_stop === 1'b1) err_t.push_back(cyc);
    if (bus.fim_recepcao === 1'b1 && bus.erro_stop === 1'b1) both_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.RX = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input bit mid);
    int unsigned t;
    t = cyc;
    bus.RX = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      if (mid && i == 4) begin
        chk("ocupado_mid", bus.ocupado, 1);
        chk("estado_mid", bus.db_estado, 2);
      end
      repeat (C) @(negedge clock);
    end
    bus.RX = stop;
    repeat (C) @(negedge clock);
    if (stop) begin
      exp_fim_t.push_back(t + LAT);
      exp_fim_d.push_back(b);
      last_good = b;
    end else begin
      exp_err_t.push_back(t + LAT);
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_nfim"}, fim_t.size(), exp_fim_t.size());
    chk({tag, "_nerr"}, err_t.size(), exp_err_t.size());
    for (int i = 0; i < fim_t.size() && i < exp_fim_t.size(); i++) begin
      chk({tag, "_fim_cyc"}, fim_t[i], exp_fim_t[i]);
      chk({tag, "_fim_dado"}, fim_d[i], exp_fim_d[i]);
    end
    for (int i = 0; i < err_t.size() && i < exp_err_t.size(); i++)
      chk({tag, "_err_cyc"}, err_t[i], exp_err_t[i]);
    fim_t.delete(); fim_d.delete(); err_t.delete();
    exp_fim_t.delete(); exp_fim_d.delete(); exp_err_t.delete();
  endtask

  initial begin
    logic [7:0] b55;
    logic [7:0] rb;
    bit         ok;
    int         gap;

    bus.RX    = 1'b1;
    reset     = 1'b0;
    last_good = 8'h00;
    b55       = 8'h55;

    repeat (3) @(negedge clock);
    chk("rst_fim", bus.fim_recepcao, 0);
    chk("rst_err", bus.erro_stop, 0);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_estado", bus.db_estado, 0);
    chk("rst_dado", bus.dado, 8'h00);
    reset = 1'b1;
    idle(2 * C);

    send(8'hA5, 1'b1, 1'b1);
    idle(2 * C);
    check_events("a5");
    chk("a5_dado", bus.dado, 8'hA5);

    bus.RX = 1'b0;
    repeat (2) @(negedge clock);
    bus.RX = 1'b1;
    repeat (2) @(negedge clock);
    chk("glitch_confirma", bus.db_estado, 1);
    idle(2 * C);
    check_events("glitch");
    chk("glitch_dado", bus.dado, 8'hA5);
    chk("glitch_estado", bus.db_estado, 0);

    send(8'h3C, 1'b0, 1'b0);
    repeat (20 * C) @(negedge clock);
    chk("frame_espera", bus.db_estado, 6);
    chk("frame_ocupado", bus.ocupado, 0);
    idle(4);
    chk("frame_inicial", bus.db_estado, 0);
    idle(C);
    check_events("framing");
    chk("frame_dado", bus.dado, 8'hA5);

    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    idle(2 * C);
    if (fim_t.size() == 2) chk("b2b_gap", fim_t[1] - fim_t[0], 80);
    else chk("b2b_count", fim_t.size(), 2);
    check_events("b2b");
    chk("b2b_dado", bus.dado, 8'hFF);

    bus.RX = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      bus.RX = b55[i];
      repeat (C) @(negedge clock);
    end
    repeat (H) @(negedge clock);
    reset  = 1'b0;
    bus.RX = 1'b1;
    @(negedge clock);
    chk("rstmid_ocupado", bus.ocupado, 0);
    chk("rstmid_estado", bus.db_estado, 0);
    @(negedge clock);
    reset     = 1'b1;
    last_good = 8'h00;
    idle(12 * C);
    check_events("rstmid");
    chk("rstmid_dado", bus.dado, 8'h00);
    send(8'h81, 1'b1, 1'b0);
    idle(2 * C);
    check_events("r81");
    chk("r81_dado", bus.dado, 8'h81);

    for (int n = 0; n < 14; n++) begin
      rb  = 8'($urandom);
      ok  = ($urandom_range(3) != 0);
      send(rb, ok, (n == 3));
      gap = ok ? int'($urandom_range(2 * C)) : 2 * C + int'($urandom_range(C));
      idle(gap);
    end
    idle(2 * C);
    check_events("rand");
    chk("rand_dado", bus.dado, last_good);
    chk("never_both", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
